// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding command/response to APB3 master bridge
module apb_master_bridge #(
    parameter int NUM_SLAVES     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic [31:0] PADDR,
    output logic [15:0] PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    // Counter is wide enough to hold TIMEOUT_CYCLES; it aborts on the cycle
    // that would bring it to the limit, so ACCESS lasts TIMEOUT_CYCLES cycles.
    localparam int             CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [4:0]     NS       = 5'(NUM_SLAVES);
    localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    paddr_q, paddr_d;
    logic           pwrite_q, pwrite_d;
    logic [31:0]    pwdata_q, pwdata_d;
    logic [15:0]    psel_q, psel_d;
    logic           penable_q, penable_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_slverr_q, rsp_slverr_d;
    logic           rsp_timeout_q, rsp_timeout_d;

    logic           accept;
    logic           sel_ok;
    logic           timeout_hit;

    assign cmd_ready   = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);
    assign accept      = cmd_valid && cmd_ready;
    assign sel_ok      = ({1'b0, cmd_sel} < NS);
    assign timeout_hit = TO_EN && !PREADY && (cnt_q == CNT_LAST);

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

    // Next-state and next-output computation for the transfer FSM and response slot
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        // A consumed response frees the slot; a response loaded below wins.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    if (sel_ok) begin
                        state_d = ST_SETUP;
                        psel_d  = 16'(1) << cmd_sel;
                        cnt_d   = '0;
                    end else begin
                        // Nonexistent slave: answer with an error, no bus cycle
                        rsp_valid_d   = 1'b1;
                        rsp_slverr_d  = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a timeout on the same cycle
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                end else if (timeout_hit) begin
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transfer or response in flight
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule
